pc_sequencer: RTL and testbench

Next-PC selection and stall/flush controller for the RV32I 5-stage pipeline. It drives the PC register's `PCWrite`/`nextPC` pair and the IF/ID and ID/EX pipeline-register controls. It resolves EX-stage redirects, load-use hazards and instruction-memory wait cycles. A redirect that arrives while a fetch is outstanding is held until that fetch returns. It also keeps saturating stall and flush performance counters.

---
 rtl/pc_seq_pkg.sv | 6 +
 rtl/load_use_detect.sv | 17 +
 rtl/pc_sequencer.sv | 117 +++++++++++
 tb/tb_pc_sequencer.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the PC sequencer and related hazard logic.
package pc_seq_pkg;
   typedef enum logic [1:0] {BOOT, RUN, PEND} seq_state_e;
   localparam logic [31:0] PC_STEP       = 32'd4;
   localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;
endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard comparator between the ID sources and a load in EX.
module load_use_detect (
   input  logic       ex_mem_read,
   input  logic [4:0] ex_rd,
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   input  logic       id_uses_rs1,
   input  logic       id_uses_rs2,
   output logic       load_use
);
   logic hit_rs1, hit_rs2;

   assign hit_rs1  = id_uses_rs1 && (id_rs1 == ex_rd);
   assign hit_rs2  = id_uses_rs2 && (id_rs2 == ex_rd);
   // x0 is never a real producer, so a load targeting it cannot create a hazard.
   assign load_use = ex_mem_read && (ex_rd != 5'd0) && (hit_rs1 || hit_rs2);
endmodule

// File: rtl/pc_sequencer.sv
// Next-PC selection, stall/flush control and saturating perf counters for the
// 5-stage pipeline; redirects that meet an outstanding fetch are parked in PEND.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          CNT_W    = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [31:0]      IF_PC,
   input  logic             imem_ready,
   input  logic [4:0]       ID_rs1,
   input  logic [4:0]       ID_rs2,
   input  logic             ID_uses_rs1,
   input  logic             ID_uses_rs2,
   input  logic             EX_MemRead,
   input  logic [4:0]       EX_rd,
   input  logic             EX_redirect,
   input  logic [31:0]      EX_target,
   output logic             PCWrite,
   output logic [31:0]      nextPC,
   output logic             IF_ID_Write,
   output logic             IF_ID_Flush,
   output logic             ID_EX_Flush,
   output logic [CNT_W-1:0] perf_stall_cnt,
   output logic [CNT_W-1:0] perf_flush_cnt
);
   seq_state_e       state_q, state_d;
   logic [31:0]      pend_target_q, pend_target_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic             load_use, stall_evt, flush_evt;

   load_use_detect u_lud (
      .ex_mem_read (EX_MemRead),
      .ex_rd       (EX_rd),
      .id_rs1      (ID_rs1),
      .id_rs2      (ID_rs2),
      .id_uses_rs1 (ID_uses_rs1),
      .id_uses_rs2 (ID_uses_rs2),
      .load_use    (load_use)
   );

   always_comb begin
      state_d       = state_q;
      pend_target_d = pend_target_q;
      PCWrite       = 1'b0;
      nextPC        = IF_PC & PC_ALIGN_MASK;
      IF_ID_Write   = 1'b1;
      IF_ID_Flush   = 1'b0;
      ID_EX_Flush   = 1'b0;
      flush_evt     = 1'b0;
      unique case (state_q)
         BOOT: begin
            PCWrite     = 1'b1;
            nextPC      = RESET_PC & PC_ALIGN_MASK;
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
            state_d     = RUN;
         end
         RUN: begin
            if (EX_redirect && imem_ready) begin
               PCWrite     = 1'b1;
               nextPC      = EX_target & PC_ALIGN_MASK;
               IF_ID_Flush = 1'b1;
               ID_EX_Flush = 1'b1;
               flush_evt   = 1'b1;
            end else if (EX_redirect) begin
               pend_target_d = EX_target & PC_ALIGN_MASK;
               state_d       = PEND;
               IF_ID_Flush   = 1'b1;
               ID_EX_Flush   = 1'b1;
               flush_evt     = 1'b1;
            end else if (load_use) begin
               IF_ID_Write = 1'b0;
               ID_EX_Flush = 1'b1;
            end else if (!imem_ready) begin
               IF_ID_Flush = 1'b1;
            end else begin
               PCWrite = 1'b1;
               nextPC  = (IF_PC + PC_STEP) & PC_ALIGN_MASK;
            end
         end
         PEND: begin
            // Whatever word returns here is wrong-path, so IF/ID always gets a NOP.
            IF_ID_Flush = 1'b1;
            if (imem_ready) begin
               PCWrite = 1'b1;
               nextPC  = pend_target_q;
               state_d = RUN;
            end
         end
         default: state_d = BOOT;
      endcase
      stall_evt   = (state_q != BOOT) && !PCWrite;
      stall_cnt_d = (stall_evt && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
      flush_cnt_d = (flush_evt && !(&flush_cnt_q)) ? flush_cnt_q + 1'b1 : flush_cnt_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= BOOT;
         pend_target_q <= '0;
         stall_cnt_q   <= '0;
         flush_cnt_q   <= '0;
      end else begin
         state_q       <= state_d;
         pend_target_q <= pend_target_d;
         stall_cnt_q   <= stall_cnt_d;
         flush_cnt_q   <= flush_cnt_d;
      end
   end

   assign perf_stall_cnt = stall_cnt_q;
   assign perf_flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Random and directed checks of pc_sequencer against a rule-level reference model.
module tb_pc_sequencer;
   localparam int          CNT_W  = 8;
   localparam int          CMAX   = 255;
   localparam logic [31:0] RST_PC = 32'h0000_0100;

   logic             clk = 1'b0;
   logic             reset_n;
   logic [31:0]      IF_PC, EX_target, nextPC;
   logic             imem_ready, ID_uses_rs1, ID_uses_rs2, EX_MemRead, EX_redirect;
   logic [4:0]       ID_rs1, ID_rs2, EX_rd;
   logic             PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush;
   logic [CNT_W-1:0] perf_stall_cnt, perf_flush_cnt;

   pc_sequencer #(.RESET_PC(RST_PC), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset_n(reset_n), .IF_PC(IF_PC), .imem_ready(imem_ready),
      .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_uses_rs1(ID_uses_rs1), .ID_uses_rs2(ID_uses_rs2),
      .EX_MemRead(EX_MemRead), .EX_rd(EX_rd), .EX_redirect(EX_redirect), .EX_target(EX_target),
      .PCWrite(PCWrite), .nextPC(nextPC), .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush),
      .ID_EX_Flush(ID_EX_Flush), .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0, failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference model: mode 0=boot, 1=run, 2=waiting for the fetch to return
   int          m_mode, m_stall, m_flush;
   logic [31:0] m_pc, m_tgt;
   bit          e_pw, e_idw, e_iff, e_idf, e_st_inc, e_fl_inc;
   logic [31:0] e_npc, n_tgt;
   int          n_mode;
   bit          obs_pw;
   logic [31:0] obs_npc;

   task automatic predict();
      bit lu;
      lu = EX_MemRead && EX_rd != 0 &&
           ((ID_uses_rs1 && ID_rs1 == EX_rd) || (ID_uses_rs2 && ID_rs2 == EX_rd));
      e_pw = 0; e_npc = {IF_PC[31:2], 2'b00}; e_idw = 1; e_iff = 0; e_idf = 0;
      e_fl_inc = 0; n_mode = m_mode; n_tgt = m_tgt;
      if (m_mode == 0) begin
         e_pw = 1; e_npc = RST_PC; e_iff = 1; e_idf = 1; n_mode = 1;
      end else if (m_mode == 1) begin
         if (EX_redirect) begin
            e_iff = 1; e_idf = 1; e_fl_inc = 1;
            if (imem_ready) begin
               e_pw = 1; e_npc = {EX_target[31:2], 2'b00};
            end else begin
               n_tgt = {EX_target[31:2], 2'b00}; n_mode = 2;
            end
         end else if (lu) begin
            e_idw = 0; e_idf = 1;
         end else if (!imem_ready) begin
            e_iff = 1;
         end else begin
            e_pw = 1; e_npc = IF_PC + 32'd4;
         end
      end else begin
         e_iff = 1;
         if (imem_ready) begin
            e_pw = 1; e_npc = m_tgt; n_mode = 1;
         end
      end
      e_st_inc = (m_mode != 0) && !e_pw;
   endtask

   task automatic step();
      @(negedge clk);
      predict();
      check("PCWrite", 32'(PCWrite), 32'(e_pw));
      check("nextPC", nextPC, e_npc);
      check("IF_ID_Write", 32'(IF_ID_Write), 32'(e_idw));
      check("IF_ID_Flush", 32'(IF_ID_Flush), 32'(e_iff));
      check("ID_EX_Flush", 32'(ID_EX_Flush), 32'(e_idf));
      check("stall_cnt", 32'(perf_stall_cnt), 32'(m_stall));
      check("flush_cnt", 32'(perf_flush_cnt), 32'(m_flush));
      obs_pw = PCWrite; obs_npc = nextPC;
      @(posedge clk);
      #1;
      if (!reset_n) begin
         m_mode = 0; m_stall = 0; m_flush = 0; m_tgt = 0;
      end else begin
         m_mode = n_mode; m_tgt = n_tgt;
         if (e_pw) m_pc = e_npc;
         if (e_st_inc && m_stall < CMAX) m_stall++;
         if (e_fl_inc && m_flush < CMAX) m_flush++;
      end
      IF_PC = m_pc;
   endtask

   task automatic drive(input bit rdy, input bit redir, input logic [31:0] tgt,
                        input bit mr, input logic [4:0] rd, input logic [4:0] r1,
                        input logic [4:0] r2, input bit u1, input bit u2);
      imem_ready = rdy; EX_redirect = redir; EX_target = tgt; EX_MemRead = mr;
      EX_rd = rd; ID_rs1 = r1; ID_rs2 = r2; ID_uses_rs1 = u1; ID_uses_rs2 = u2;
   endtask

   task automatic reset_model();
      m_mode = 0; m_stall = 0; m_flush = 0; m_tgt = 0;
   endtask

   task automatic rand_steps(input int n);
      for (int i = 0; i < n; i++) begin
         drive($urandom_range(3, 0) != 0, $urandom_range(4, 0) == 0, $urandom,
               $urandom_range(1, 0) == 1, 5'($urandom_range(7, 0)), 5'($urandom_range(7, 0)),
               5'($urandom_range(7, 0)), $urandom_range(1, 0) == 1, $urandom_range(1, 0) == 1);
         if ($urandom_range(63, 0) == 0) begin
            m_pc = 32'hFFFF_FFFC; IF_PC = m_pc;
         end
         step();
      end
   endtask

   initial begin
      reset_n = 1'b0; m_pc = 32'h0; IF_PC = 32'h0;
      reset_model();
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
      step();
      check("rst_cnt", 32'(perf_stall_cnt) + 32'(perf_flush_cnt), 32'h0);
      reset_n = 1'b1;
      step();                          // BOOT -> 0x100
      check("boot_pc", obs_npc, 32'h100);
      step(); check("step1", obs_npc, 32'h104);
      step(); check("step2", obs_npc, 32'h108);

      drive(1, 0, 0, 1, 5, 5, 0, 1, 0);  // lw x5 in EX, ID reads x5
      step(); check("lu_pw", 32'(obs_pw), 32'h0);
      drive(1, 0, 0, 0, 5, 5, 0, 1, 0);
      step(); check("lu_one_cycle", 32'(obs_pw), 32'h1);
      check("lu_stall_cnt", 32'(perf_stall_cnt), 32'h1);
      drive(1, 0, 0, 1, 0, 0, 0, 1, 1);  // rd=x0 never stalls
      step(); check("lu_x0", 32'(obs_pw), 32'h1);

      drive(1, 1, 32'h203, 0, 0, 0, 0, 0, 0);
      step(); check("redir_pc", obs_npc, 32'h200);
      check("redir_flush_cnt", 32'(perf_flush_cnt), 32'h1);

      drive(0, 1, 32'h400, 0, 0, 0, 0, 0, 0); step();
      drive(0, 1, 32'h800, 0, 0, 0, 0, 0, 0); step();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);       step();
      drive(1, 1, 32'h800, 0, 0, 0, 0, 0, 0); step();
      check("pend_pc", obs_npc, 32'h400);

      drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
      m_pc = 32'hFFFF_FFFC; IF_PC = m_pc;
      step(); check("wrap", obs_npc, 32'h0);

      rand_steps(1500);

      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 300; i++) step();
      drive(1, 1, 32'h1000, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 300; i++) step();
      check("stall_sat", 32'(perf_stall_cnt), 32'hFF);
      check("flush_sat", 32'(perf_flush_cnt), 32'hFF);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0); step();
      check("stall_hold", 32'(perf_stall_cnt), 32'hFF);

      drive(0, 1, 32'h400, 0, 0, 0, 0, 0, 0); step();   // now in PEND
      reset_n = 1'b0; reset_model();
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
      step();
      check("pend_rst_cnt", 32'(perf_stall_cnt) + 32'(perf_flush_cnt), 32'h0);
      reset_n = 1'b1;
      step(); check("pend_rst_boot", obs_npc, 32'h100);
      rand_steps(300);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
